// File: rtl/id_ex_elastic_stage.sv
// ID/EX pipeline boundary with valid/ready handshaking on both sides.
// Holds the decoded instruction bundle in a main entry (always the one
// presented to execute) and, when SKID != 0, a second skid entry that
// absorbs the bundle already in flight when execute stops accepting.
// A load-use detector holds a dependent bundle back until the load has
// left this stage, and a saturating counter records those stall cycles.
//
// Handshake semantics (both sides): a transfer happens at a rising clk edge
// when valid and ready are both high. A producer holding valid keeps its
// payload stable until the transfer; ready may depend on valid on the input
// side only through the load-use check. out_valid never depends on out_ready.

module id_ex_elastic_stage #(
  parameter int XLEN          = 32,
  parameter int REGW          = 5,
  parameter int CTRLW         = 11,
  parameter int SKID          = 1,
  parameter int LOADUSE_CHECK = 1,
  parameter int CNTW          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  // decode side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_rd1,
  input  logic [XLEN-1:0]  in_rd2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [CTRLW-1:0] in_ctrl,
  input  logic [REGW-1:0]  in_rs1,
  input  logic [REGW-1:0]  in_rs2,
  input  logic [REGW-1:0]  in_rd,
  // execute side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc4,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_rd1,
  output logic [XLEN-1:0]  out_rd2,
  output logic [XLEN-1:0]  out_imm,
  output logic [CTRLW-1:0] out_ctrl,
  output logic [REGW-1:0]  out_rs1,
  output logic [REGW-1:0]  out_rs2,
  output logic [REGW-1:0]  out_rd,
  // hazard / performance
  output logic             load_use_stall,
  output logic [CNTW-1:0]  bubble_count
);

  // Control word layout: RegWrite is the MSB, ResultSrc occupies [1:0].
  localparam int          CTRL_REGWRITE   = CTRLW - 1;
  localparam logic [1:0]  RESULTSRC_LOAD  = 2'b01;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc4;
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  imm;
    logic [CTRLW-1:0] ctrl;
    logic [REGW-1:0]  rs1;
    logic [REGW-1:0]  rs2;
    logic [REGW-1:0]  rd;
  } bundle_t;

  bundle_t         in_bundle;
  bundle_t         main_q, main_d;
  bundle_t         skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [CNTW-1:0] bubble_q, bubble_d;

  logic            main_hit;
  logic            skid_hit;
  logic            hazard;
  logic            stall;
  logic            in_ready_int;
  logic            in_xfer;
  logic            out_xfer;

  // Gather the decode-side payload into one bundle.
  always_comb begin
    in_bundle       = '0;
    in_bundle.pc    = in_pc;
    in_bundle.pc4   = in_pc4;
    in_bundle.instr = in_instr;
    in_bundle.rd1   = in_rd1;
    in_bundle.rd2   = in_rd2;
    in_bundle.imm   = in_imm;
    in_bundle.ctrl  = in_ctrl;
    in_bundle.rs1   = in_rs1;
    in_bundle.rs2   = in_rs2;
    in_bundle.rd    = in_rd;
  end

  // Load-use detection against the youngest held entry (skid if occupied).
  always_comb begin
    main_hit = main_q.ctrl[CTRL_REGWRITE]
             & (main_q.ctrl[1:0] == RESULTSRC_LOAD)
             & (main_q.rd != '0)
             & ((main_q.rd == in_rs1) | (main_q.rd == in_rs2));
    skid_hit = skid_q.ctrl[CTRL_REGWRITE]
             & (skid_q.ctrl[1:0] == RESULTSRC_LOAD)
             & (skid_q.rd != '0)
             & ((skid_q.rd == in_rs1) | (skid_q.rd == in_rs2));
    hazard = 1'b0;
    if (LOADUSE_CHECK != 0) begin
      hazard = skid_valid_q ? skid_hit : (main_valid_q & main_hit);
    end
    stall = in_valid & hazard;
  end

  // Input acceptance: with a skid entry, ready depends only on registered
  // occupancy (no path from out_ready); without it, main must be free or
  // leaving this cycle. Held low while reset is asserted.
  always_comb begin
    if (SKID != 0) begin
      in_ready_int = ~skid_valid_q & ~stall;
    end else begin
      in_ready_int = (~main_valid_q | out_ready) & ~stall;
    end
    in_ready_int = in_ready_int & ~rst;
    in_xfer      = in_valid & in_ready_int;
    out_xfer     = main_valid_q & out_ready;
  end

  // Next-state for the entries: flush kills everything; otherwise keep
  // FIFO order by promoting skid into main before taking new input.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_d       = '0;
      main_valid_d = 1'b0;
      skid_d       = '0;
      skid_valid_d = 1'b0;
    end else if (out_xfer) begin
      if (skid_valid_q) begin
        // in_ready is low whenever skid is occupied, so no input here.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        // Simultaneous in/out on a full main: replace in place.
        main_d       = in_bundle;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_valid_q) begin
        main_d       = in_bundle;
        main_valid_d = 1'b1;
      end else if (SKID != 0) begin
        // Main is held by execute: park the in-flight bundle in skid.
        skid_d       = in_bundle;
        skid_valid_d = 1'b1;
      end
    end
  end

  // Stall-cycle counter, saturating at all-ones; flush leaves it alone.
  always_comb begin
    bubble_d = bubble_q;
    if (stall && (bubble_q != {CNTW{1'b1}})) begin
      bubble_d = bubble_q + CNTW'(1);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      bubble_q     <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      bubble_q     <= bubble_d;
    end
  end

  // Execute side is always driven from the main entry.
  assign in_ready       = in_ready_int;
  assign out_valid      = main_valid_q;
  assign out_pc         = main_q.pc;
  assign out_pc4        = main_q.pc4;
  assign out_instr      = main_q.instr;
  assign out_rd1        = main_q.rd1;
  assign out_rd2        = main_q.rd2;
  assign out_imm        = main_q.imm;
  assign out_ctrl       = main_q.ctrl;
  assign out_rs1        = main_q.rs1;
  assign out_rs2        = main_q.rs2;
  assign out_rd         = main_q.rd;
  assign load_use_stall = stall;
  assign bubble_count   = bubble_q;

endmodule

// File: tb/tb_id_ex_elastic_stage.sv
// Directed bench for id_ex_elastic_stage: one instance with the skid entry
// (16-bit counter) and one single-register instance (4-bit counter) share
// the decode-side stimulus; per-instance enables gate in_valid so each can
// be exercised alone where their acceptance differs.

module tb_id_ex_elastic_stage;

  localparam int BW = 6 * 32 + 11 + 3 * 5;
  localparam logic [10:0] CTRL_ALU = 11'h400;  // RegWrite, ResultSrc=00
  localparam logic [10:0] CTRL_LW  = 11'h401;  // RegWrite, ResultSrc=01

  logic        clk, rst, flush, in_valid, out_ready, en_s, en_r;
  logic [31:0] in_pc, in_pc4, in_instr, in_rd1, in_rd2, in_imm;
  logic [10:0] in_ctrl;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        s_in_valid, r_in_valid;

  logic        s_in_ready, s_out_valid, s_stall;
  logic [31:0] s_pc, s_pc4, s_instr, s_rd1, s_rd2, s_imm;
  logic [10:0] s_ctrl;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [15:0] s_bubble;

  logic        r_in_ready, r_out_valid, r_stall;
  logic [31:0] r_pc, r_pc4, r_instr, r_rd1, r_rd2, r_imm;
  logic [10:0] r_ctrl;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [3:0]  r_bubble;

  logic [BW-1:0] s_bun, r_bun;

  int n_vec = 0;
  int n_err = 0;

  assign s_in_valid = in_valid & en_s;
  assign r_in_valid = in_valid & en_r;
  assign s_bun = {s_pc, s_pc4, s_instr, s_rd1, s_rd2, s_imm, s_ctrl, s_rs1, s_rs2, s_rd};
  assign r_bun = {r_pc, r_pc4, r_instr, r_rd1, r_rd2, r_imm, r_ctrl, r_rs1, r_rs2, r_rd};

  id_ex_elastic_stage #(.SKID(1), .CNTW(16)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_pc4(in_pc4), .in_instr(in_instr), .in_rd1(in_rd1),
    .in_rd2(in_rd2), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_pc), .out_pc4(s_pc4), .out_instr(s_instr), .out_rd1(s_rd1),
    .out_rd2(s_rd2), .out_imm(s_imm), .out_ctrl(s_ctrl),
    .out_rs1(s_rs1), .out_rs2(s_rs2), .out_rd(s_rd),
    .load_use_stall(s_stall), .bubble_count(s_bubble)
  );

  id_ex_elastic_stage #(.SKID(0), .CNTW(4)) u_reg (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_pc(in_pc), .in_pc4(in_pc4), .in_instr(in_instr), .in_rd1(in_rd1),
    .in_rd2(in_rd2), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(r_out_valid), .out_ready(out_ready),
    .out_pc(r_pc), .out_pc4(r_pc4), .out_instr(r_instr), .out_rd1(r_rd1),
    .out_rd2(r_rd2), .out_imm(r_imm), .out_ctrl(r_ctrl),
    .out_rs1(r_rs1), .out_rs2(r_rs2), .out_rd(r_rd),
    .load_use_stall(r_stall), .bubble_count(r_bubble)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bundle as the execute side should see it.
  function automatic logic [BW-1:0] mk(input logic [31:0] pc, input logic [10:0] ctrl,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd);
    return {pc, pc + 32'd4, pc ^ 32'h1357_9BDF, pc + 32'h1000, pc + 32'h2000, ~pc,
            ctrl, rs1, rs2, rd};
  endfunction

  function automatic logic [BW-1:0] mk_std(input logic [31:0] pc);
    return mk(pc, CTRL_ALU, 5'd1, 5'd2, 5'd3);
  endfunction

  // Driver tasks
  task automatic drive(input logic v, input logic [31:0] pc, input logic [10:0] ctrl,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    in_valid = v;
    in_pc    = pc;
    in_pc4   = pc + 32'd4;
    in_instr = pc ^ 32'h1357_9BDF;
    in_rd1   = pc + 32'h1000;
    in_rd2   = pc + 32'h2000;
    in_imm   = ~pc;
    in_ctrl  = ctrl;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
  endtask

  task automatic drive_std(input logic [31:0] pc);
    drive(1'b1, pc, CTRL_ALU, 5'd1, 5'd2, 5'd3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checkers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; en_s = 1'b1; en_r = 1'b1;
    drive(1'b0, 32'h0, 11'h0, 5'd0, 5'd0, 5'd0);

    // ---------------- reset state ----------------
    @(posedge clk); #1;
    chk("rst_s_in_ready", 32'(s_in_ready), 32'd0);
    chk("rst_r_in_ready", 32'(r_in_ready), 32'd0);
    chk("rst_s_out_valid", 32'(s_out_valid), 32'd0);
    chk("rst_r_out_valid", 32'(r_out_valid), 32'd0);
    chk_b("rst_s_bundle", s_bun, '0);
    chk("rst_s_bubble", 32'(s_bubble), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rel_s_in_ready", 32'(s_in_ready), 32'd1);
    chk("rel_r_in_ready", 32'(r_in_ready), 32'd1);

    // ---------------- streaming, both modes ----------------
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive_std(32'(i * 4));
      else in_valid = 1'b0;
      #1;
      if (i > 0) begin
        chk("stream_s_valid", 32'(s_out_valid), 32'd1);
        chk("stream_r_valid", 32'(r_out_valid), 32'd1);
        chk_b("stream_s_bundle", s_bun, mk_std(32'((i - 1) * 4)));
        chk_b("stream_r_bundle", r_bun, mk_std(32'((i - 1) * 4)));
      end else begin
        chk("stream_s_first_empty", 32'(s_out_valid), 32'd0);
      end
      chk("stream_s_in_ready", 32'(s_in_ready), 32'd1);
      chk("stream_r_in_ready", 32'(r_in_ready), 32'd1);
      tick();
    end
    chk("stream_s_drained", 32'(s_out_valid), 32'd0);
    chk("stream_r_drained", 32'(r_out_valid), 32'd0);

    // ---------------- backpressure, skid mode ----------------
    en_r = 1'b0;
    drive_std(32'h100); #1;
    chk("bp_s_c0_ready", 32'(s_in_ready), 32'd1);
    tick();
    drive_std(32'h104); #1;
    chk_b("bp_s_c1_out", s_bun, mk_std(32'h100));
    tick();
    drive_std(32'h108); out_ready = 1'b0; #1;
    chk_b("bp_s_c2_out", s_bun, mk_std(32'h104));
    chk("bp_s_c2_ready", 32'(s_in_ready), 32'd1);
    tick();
    drive_std(32'h10C); #1;
    chk_b("bp_s_c3_out", s_bun, mk_std(32'h104));
    chk("bp_s_c3_ready", 32'(s_in_ready), 32'd0);
    tick(); #1;
    chk_b("bp_s_c4_out", s_bun, mk_std(32'h104));
    chk("bp_s_c4_ready", 32'(s_in_ready), 32'd0);
    tick();
    out_ready = 1'b1; #1;
    chk_b("bp_s_c5_out", s_bun, mk_std(32'h104));
    chk("bp_s_c5_ready", 32'(s_in_ready), 32'd0);
    chk("bp_s_c5_valid", 32'(s_out_valid), 32'd1);
    tick(); #1;
    chk_b("bp_s_c6_out", s_bun, mk_std(32'h108));
    chk("bp_s_c6_ready", 32'(s_in_ready), 32'd1);
    tick();
    in_valid = 1'b0; #1;
    chk_b("bp_s_c7_out", s_bun, mk_std(32'h10C));
    tick(); #1;
    chk("bp_s_empty", 32'(s_out_valid), 32'd0);
    chk("bp_r_untouched", 32'(r_out_valid), 32'd0);

    // ---------------- backpressure, single register ----------------
    en_s = 1'b0; en_r = 1'b1;
    drive_std(32'h200); #1;
    chk("bp_r_c0_ready", 32'(r_in_ready), 32'd1);
    tick();
    drive_std(32'h204); #1;
    chk_b("bp_r_c1_out", r_bun, mk_std(32'h200));
    tick();
    drive_std(32'h208); out_ready = 1'b0; #1;
    chk_b("bp_r_c2_out", r_bun, mk_std(32'h204));
    chk("bp_r_c2_ready", 32'(r_in_ready), 32'd0);
    tick(); #1;
    chk_b("bp_r_c3_out", r_bun, mk_std(32'h204));
    chk("bp_r_c3_ready", 32'(r_in_ready), 32'd0);
    tick(); #1;
    chk("bp_r_c4_ready", 32'(r_in_ready), 32'd0);
    tick();
    out_ready = 1'b1; #1;
    chk("bp_r_c5_ready", 32'(r_in_ready), 32'd1);
    chk_b("bp_r_c5_out", r_bun, mk_std(32'h204));
    tick();
    in_valid = 1'b0; #1;
    chk_b("bp_r_c6_out", r_bun, mk_std(32'h208));
    tick(); #1;
    chk("bp_r_empty", 32'(r_out_valid), 32'd0);

    // ---------------- load-use ----------------
    en_s = 1'b1; en_r = 1'b1;
    drive(1'b1, 32'h300, CTRL_LW, 5'd2, 5'd0, 5'd5); #1;
    chk("lu_lw_no_stall", 32'(s_stall), 32'd0);
    chk("lu_lw_ready", 32'(s_in_ready), 32'd1);
    tick();
    drive(1'b1, 32'h304, CTRL_ALU, 5'd5, 5'd1, 5'd6); #1;
    chk("lu_s_stall", 32'(s_stall), 32'd1);
    chk("lu_r_stall", 32'(r_stall), 32'd1);
    chk("lu_s_ready_low", 32'(s_in_ready), 32'd0);
    chk("lu_r_ready_low", 32'(r_in_ready), 32'd0);
    chk_b("lu_s_lw_out", s_bun, mk(32'h300, CTRL_LW, 5'd2, 5'd0, 5'd5));
    chk("lu_s_bubble0", 32'(s_bubble), 32'd0);
    tick(); #1;
    chk("lu_s_stall_clear", 32'(s_stall), 32'd0);
    chk("lu_s_ready_back", 32'(s_in_ready), 32'd1);
    chk("lu_s_bubble_gap", 32'(s_out_valid), 32'd0);
    chk("lu_r_bubble_gap", 32'(r_out_valid), 32'd0);
    chk("lu_s_bubble1", 32'(s_bubble), 32'd1);
    chk("lu_r_bubble1", 32'(r_bubble), 32'd1);
    tick();
    in_valid = 1'b0; #1;
    chk_b("lu_s_add_out", s_bun, mk(32'h304, CTRL_ALU, 5'd5, 5'd1, 5'd6));
    chk_b("lu_r_add_out", r_bun, mk(32'h304, CTRL_ALU, 5'd5, 5'd1, 5'd6));
    tick();
    drive(1'b1, 32'h310, CTRL_LW, 5'd1, 5'd2, 5'd0); #1;
    tick();
    drive(1'b1, 32'h314, CTRL_ALU, 5'd0, 5'd1, 5'd7); #1;
    chk("lu_rd0_s_stall", 32'(s_stall), 32'd0);
    chk("lu_rd0_r_stall", 32'(r_stall), 32'd0);
    chk("lu_rd0_s_ready", 32'(s_in_ready), 32'd1);
    chk_b("lu_rd0_s_out", s_bun, mk(32'h310, CTRL_LW, 5'd1, 5'd2, 5'd0));
    tick();
    drive(1'b1, 32'h320, CTRL_LW, 5'd1, 5'd2, 5'd7); #1;
    chk_b("lu_rd0_s_next", s_bun, mk(32'h314, CTRL_ALU, 5'd0, 5'd1, 5'd7));
    chk("lu_alu_no_stall", 32'(s_stall), 32'd0);
    tick();
    drive(1'b1, 32'h324, CTRL_ALU, 5'd3, 5'd7, 5'd8); #1;
    chk("lu_rs2_s_stall", 32'(s_stall), 32'd1);
    chk("lu_rs2_r_stall", 32'(r_stall), 32'd1);
    tick(); #1;
    chk("lu_rs2_gap", 32'(s_out_valid), 32'd0);
    chk("lu_rs2_clear", 32'(s_stall), 32'd0);
    tick();
    in_valid = 1'b0; #1;
    chk_b("lu_rs2_out", s_bun, mk(32'h324, CTRL_ALU, 5'd3, 5'd7, 5'd8));
    chk("lu_s_bubble2", 32'(s_bubble), 32'd2);
    chk("lu_r_bubble2", 32'(r_bubble), 32'd2);
    tick(); #1;
    chk("lu_empty", 32'(s_out_valid), 32'd0);

    // ---------------- flush with two held entries ----------------
    en_r = 1'b0;
    drive_std(32'h400); #1;
    tick();
    drive_std(32'h404); out_ready = 1'b0; #1;
    chk_b("fl_c1_out", s_bun, mk_std(32'h400));
    tick();
    drive_std(32'h408); flush = 1'b1; #1;
    chk("fl_c2_ready", 32'(s_in_ready), 32'd0);
    chk("fl_c2_valid", 32'(s_out_valid), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("fl_valid_low", 32'(s_out_valid), 32'd0);
    chk_b("fl_zero", s_bun, '0);
    chk("fl_ready_back", 32'(s_in_ready), 32'd1);
    tick();
    drive_std(32'h40C); flush = 1'b1; #1;
    chk("fl_offer_ready", 32'(s_in_ready), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("fl_offer_dropped", 32'(s_out_valid), 32'd0);
    chk_b("fl_offer_zero", s_bun, '0);
    chk("fl_bubble_kept", 32'(s_bubble), 32'd2);
    tick();

    // ---------------- async reset mid-backpressure ----------------
    en_r = 1'b1;
    drive_std(32'h500); out_ready = 1'b1; #1;
    tick();
    drive_std(32'h504); out_ready = 1'b0; #1;
    tick();
    in_valid = 1'b0; #1;
    chk_b("ar_s_held", s_bun, mk_std(32'h500));
    chk_b("ar_r_held", r_bun, mk_std(32'h500));
    #1; rst = 1'b1; #1;
    chk("ar_s_valid", 32'(s_out_valid), 32'd0);
    chk("ar_r_valid", 32'(r_out_valid), 32'd0);
    chk_b("ar_s_zero", s_bun, '0);
    chk_b("ar_r_zero", r_bun, '0);
    chk("ar_s_bubble", 32'(s_bubble), 32'd0);
    chk("ar_r_bubble", 32'(r_bubble), 32'd0);
    chk("ar_s_ready", 32'(s_in_ready), 32'd0);
    chk("ar_r_ready", 32'(r_in_ready), 32'd0);
    @(posedge clk); @(negedge clk); rst = 1'b0;
    drive_std(32'h600); out_ready = 1'b1; #1;
    chk("ar_rel_ready", 32'(s_in_ready), 32'd1);
    chk("ar_rel_valid", 32'(s_out_valid), 32'd0);
    tick();
    in_valid = 1'b0; #1;
    chk("ar_first_valid", 32'(s_out_valid), 32'd1);
    chk_b("ar_first_s", s_bun, mk_std(32'h600));
    chk_b("ar_first_r", r_bun, mk_std(32'h600));
    tick(); #1;
    chk("ar_drained", 32'(s_out_valid), 32'd0);

    // ---------------- counter saturation ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'h700, CTRL_LW, 5'd1, 5'd2, 5'd9); #1;
    chk("sat_lw_s_ready", 32'(s_in_ready), 32'd1);
    chk("sat_lw_r_ready", 32'(r_in_ready), 32'd1);
    tick();
    drive(1'b1, 32'h704, CTRL_ALU, 5'd9, 5'd3, 5'd10);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("sat_s_stall", 32'(s_stall), 32'd1);
      chk("sat_r_stall", 32'(r_stall), 32'd1);
      chk("sat_s_count", 32'(s_bubble), 32'(i));
      chk("sat_r_count", 32'(r_bubble), (i < 15) ? 32'(i) : 32'd15);
      tick();
    end
    in_valid = 1'b0; #1;
    chk("sat_no_valid_no_stall", 32'(s_stall), 32'd0);
    chk("sat_s_final", 32'(s_bubble), 32'd20);
    chk("sat_r_final", 32'(r_bubble), 32'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("sat_s_after_flush", 32'(s_bubble), 32'd20);
    chk("sat_r_after_flush", 32'(r_bubble), 32'd15);
    chk("sat_flush_valid", 32'(s_out_valid), 32'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
